// File: rtl/display_buttons_pkg.sv
// Shared types and register map for the display-board button scanner.
`default_nettype none

package display_buttons_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_UPDATE   = 3'd4
  } scan_state_e;

  localparam logic [1:0] ADDR_STATUS     = 2'd0;
  localparam logic [1:0] ADDR_PRESSED    = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK   = 2'd2;
  localparam logic [1:0] ADDR_SCAN_COUNT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// Per-bit scan-history debouncer: a bit changes only after DEBOUNCE_SCANS identical samples.
`default_nettype none

module button_debounce #(
  parameter int NBITS          = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [NBITS-1:0] raw_i,
  output logic [NBITS-1:0] debounced_o,
  output logic [NBITS-1:0] rise_o
);

  logic [DEBOUNCE_SCANS-1:0] hist_q [NBITS];
  logic [DEBOUNCE_SCANS-1:0] hist_d [NBITS];
  logic [NBITS-1:0]          deb_q;
  logic [NBITS-1:0]          deb_d;

  always_comb begin
    hist_d = hist_q;
    deb_d  = deb_q;
    if (valid_i) begin
      for (int i = 0; i < NBITS; i++) begin
        hist_d[i] = {hist_q[i][DEBOUNCE_SCANS-2:0], raw_i[i]};
        if (&hist_d[i]) begin
          deb_d[i] = 1'b1;
        end else if (~|hist_d[i]) begin
          deb_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBITS; i++) begin
        hist_q[i] <= '0;
      end
      deb_q <= '0;
    end else begin
      hist_q <= hist_d;
      deb_q  <= deb_d;
    end
  end

  assign debounced_o = deb_q;
  // Combinational so PRESSED can be set on the same edge STATUS changes.
  assign rise_o      = deb_d & ~deb_q;

endmodule

`default_nettype wire

// File: rtl/display_buttons_scanner.sv
// Scans the display-board button shift register, debounces it and exposes it over Avalon-MM.
`default_nettype none

module display_buttons_scanner
  import display_buttons_pkg::*;
#(
  parameter int CLK_DIV        = 25,
  parameter int NBITS          = 16,
  parameter int SCAN_INTERVAL  = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_in,
  output logic        shift_loadn,
  output logic        shift_clk,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq
);

  localparam int IW = $clog2(SCAN_INTERVAL);
  localparam int DW = $clog2(CLK_DIV);
  localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;

  scan_state_e      state_q, state_d;
  logic [IW-1:0]    int_q, int_d;
  logic [DW-1:0]    div_q, div_d;
  logic [KW-1:0]    k_q, k_d;
  logic [NBITS-1:0] raw_q, raw_d;
  logic [31:0]      scan_cnt_q, scan_cnt_d;
  logic [NBITS-1:0] pressed_q, pressed_d;
  logic [NBITS-1:0] mask_q, mask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, loadn_q, sclk_q;
  logic             sample_valid;
  logic             div_last;
  logic [NBITS-1:0] deb_state, deb_rise, w1c;
  logic             unused_wdata;

  assign div_last     = (div_q == DW'(CLK_DIV - 1));
  assign unused_wdata = ^avs_writedata;

  // Scan sequencer; the interval counter free-runs so scans stay start-to-start.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    k_d          = k_q;
    raw_d        = raw_q;
    scan_cnt_d   = scan_cnt_q;
    sample_valid = 1'b0;
    int_d        = (int_q == IW'(SCAN_INTERVAL - 1)) ? '0 : int_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (int_q == IW'(SCAN_INTERVAL - 1)) begin
          state_d = S_LOAD;
          div_d   = '0;
        end
      end
      S_LOAD: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          state_d = S_SHIFT_LO;
          div_d   = '0;
          k_d     = '0;
        end
      end
      S_SHIFT_LO: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          raw_d   = (raw_q << 1) | NBITS'(shift_in);
          state_d = S_SHIFT_HI;
          div_d   = '0;
        end
      end
      S_SHIFT_HI: begin
        div_d = div_q + 1'b1;
        if (div_last) begin
          div_d = '0;
          if (k_q == KW'(NBITS - 1)) begin
            state_d = S_UPDATE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_SHIFT_LO;
          end
        end
      end
      S_UPDATE: begin
        sample_valid = 1'b1;
        scan_cnt_d   = scan_cnt_q + 32'd1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  button_debounce #(
    .NBITS          (NBITS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (sample_valid),
    .raw_i       (~raw_q),
    .debounced_o (deb_state),
    .rise_o      (deb_rise)
  );

  // Register file; a rise overrides a simultaneous W1C on the same bit.
  always_comb begin
    w1c       = (avs_write && avs_address == ADDR_PRESSED) ? avs_writedata[NBITS-1:0] : '0;
    pressed_d = (pressed_q & ~w1c) | deb_rise;
    mask_d    = (avs_write && avs_address == ADDR_IRQ_MASK) ? avs_writedata[NBITS-1:0] : mask_q;
    rdata_d   = '0;
    if (avs_read) begin
      case (avs_address)
        ADDR_STATUS:   rdata_d = 32'(deb_state);
        ADDR_PRESSED:  rdata_d = 32'(pressed_q);
        ADDR_IRQ_MASK: rdata_d = 32'(mask_q);
        default:       rdata_d = scan_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      int_q      <= '0;
      div_q      <= '0;
      k_q        <= '0;
      raw_q      <= '0;
      scan_cnt_q <= '0;
      pressed_q  <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      loadn_q    <= 1'b1;
      sclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_q      <= int_d;
      div_q      <= div_d;
      k_q        <= k_d;
      raw_q      <= raw_d;
      scan_cnt_q <= scan_cnt_d;
      pressed_q  <= pressed_d;
      mask_q     <= mask_d;
      rdata_q    <= rdata_d;
      irq_q      <= |(pressed_d & mask_d);
      loadn_q    <= (state_d != S_LOAD);
      sclk_q     <= (state_d == S_SHIFT_HI);
    end
  end

  assign shift_loadn  = loadn_q;
  assign shift_clk    = sclk_q;
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_display_buttons_scanner.sv
// Directed and randomized check of the button scanner against a scan-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_display_buttons_scanner;
  import display_buttons_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int NBITS   = 16;
  localparam int SI      = 100;
  localparam int DS      = 4;
  localparam int UPD_OFS = (2 * NBITS + 1) * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        shift_in;
  logic        shift_loadn, shift_clk, irq;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;

  int n_cmp = 0;
  int n_err = 0;
  int rel_cnt = 0;

  // Board: parallel-load while loadn is low, shift on each shift_clk rise.
  logic [15:0] word = 16'hFFFF;
  logic [15:0] sr = 16'hFFFF;
  logic        sclk_prev = 1'b0;

  // Reference model state (pressed = 1).
  logic [15:0] hist_m [$];
  logic [15:0] deb_m, pressed_m, mask_m;
  logic [31:0] scans_m;

  always #5 clk = ~clk;

  assign shift_in = sr[15];

  always @(posedge clk) begin
    if (!shift_loadn) sr <= word;
    else if (shift_clk && !sclk_prev) sr <= sr << 1;
    sclk_prev <= shift_clk;
    rel_cnt   <= reset ? 0 : rel_cnt + 1;
  end

  display_buttons_scanner #(
    .CLK_DIV(CLK_DIV), .NBITS(NBITS), .SCAN_INTERVAL(SI), .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk(clk), .reset(reset), .shift_in(shift_in), .shift_loadn(shift_loadn),
    .shift_clk(shift_clk), .avs_address(avs_address), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist_m = {};
    repeat (DS) hist_m.push_back(16'h0);
    deb_m = '0; pressed_m = '0; mask_m = '0; scans_m = '0;
  endtask

  task automatic model_scan(input logic [15:0] w);
    int ones;
    logic [15:0] old;
    old = deb_m;
    hist_m.push_back(~w);
    void'(hist_m.pop_front());
    for (int b = 0; b < NBITS; b++) begin
      ones = 0;
      foreach (hist_m[j]) ones += int'(hist_m[j][b]);
      if (ones == DS) deb_m[b] = 1'b1;
      else if (ones == 0) deb_m[b] = 1'b0;
    end
    pressed_m = pressed_m | (deb_m & ~old);
    scans_m++;
  endtask

  function automatic logic irq_m();
    return |(pressed_m & mask_m);
  endfunction

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    d = avs_readdata; avs_read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
    if (a == ADDR_PRESSED) pressed_m = pressed_m & ~d[15:0];
    if (a == ADDR_IRQ_MASK) mask_m = d[15:0];
  endtask

  task automatic wait_load();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * SI && !seen; i++) begin
      @(posedge clk); #1;
      if (!shift_loadn) seen = 1'b1;
    end
    chk("load_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_scan();
    wait_load();
    repeat (UPD_OFS) @(posedge clk);
    #1;
    model_scan(word);
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    bus_read(ADDR_STATUS, d);  chk({tag, "_status"}, d, 32'(deb_m));
    bus_read(ADDR_PRESSED, d); chk({tag, "_pressed"}, d, 32'(pressed_m));
    chk({tag, "_irq"}, 32'(irq), 32'(irq_m()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [15:0] base;
    int m, bad, pulses;
    logic prev;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_loadn", 32'(shift_loadn), 32'd1);
    chk("rst_sclk", 32'(shift_clk), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    reset = 1'b0;

    // First scan timing.
    wait_load();
    chk("first_load_cycle", 32'(rel_cnt), 32'(SI));
    m = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (shift_loadn) break;
      m++;
    end
    chk("load_len", 32'(m), 32'(CLK_DIV));
    bad = 0; pulses = 0; prev = 1'b0;
    for (int j = 0; j < 2 * NBITS * CLK_DIV; j++) begin
      if (shift_clk !== logic'((j / CLK_DIV) % 2)) bad++;
      if (shift_clk && !prev) pulses++;
      prev = shift_clk;
      @(posedge clk); #1;
    end
    chk("sclk_pattern_errs", 32'(bad), 32'd0);
    chk("sclk_pulses", 32'(pulses), 32'(NBITS));
    @(posedge clk); #1;
    model_scan(word);
    bus_read(ADDR_SCAN_COUNT, d);
    chk("scan_count_1", d, 32'd1);

    // Stable press of bit 0.
    word = 16'hFFFE;
    for (int s = 0; s < 4; s++) begin
      wait_scan();
      check_regs("stable");
    end
    bus_read(ADDR_STATUS, d);
    chk("stable_status_final", d, 32'h1);
    bus_write(ADDR_IRQ_MASK, 32'h1);
    chk("irq_after_mask", 32'(irq), 32'd1);

    // Bit 3 bounces across scans.
    for (int s = 0; s < 5; s++) begin
      word = (s % 2 == 1) ? 16'hFFF6 : 16'hFFFE;
      wait_scan();
      check_regs("bounce");
      bus_read(ADDR_PRESSED, d);
      chk("bounce_pressed_b3", 32'(d[3]), 32'd0);
    end

    // W1C on a two-bit sticky word.
    word = 16'hFFEE;
    for (int s = 0; s < 4; s++) wait_scan();
    check_regs("w1c_pre");
    bus_write(ADDR_PRESSED, 32'h1);
    bus_read(ADDR_PRESSED, d);
    chk("w1c_pressed", d, 32'(pressed_m));
    chk("w1c_irq_masked", 32'(irq), 32'(irq_m()));
    bus_write(ADDR_IRQ_MASK, 32'h10);
    chk("w1c_irq_remask", 32'(irq), 32'(irq_m()));

    // W1C in the same cycle as a debounced rise on bit 0.
    word = 16'hFFEF;
    for (int s = 0; s < 4; s++) wait_scan();
    check_regs("release");
    word = 16'hFFEE;
    for (int s = 0; s < 3; s++) wait_scan();
    wait_load();
    repeat (UPD_OFS - 1) @(posedge clk);
    #1;
    avs_address = ADDR_PRESSED; avs_writedata = 32'h1; avs_write = 1'b1; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0; avs_read = 1'b0;
    chk("read_pre_update", avs_readdata, 32'(pressed_m));
    pressed_m = pressed_m & ~16'h1;
    model_scan(word);
    check_regs("collision");

    // Randomized bouncy words with random W1C and mask traffic.
    base = 16'hFFFF;
    for (int it = 0; it < 12; it++) begin
      if (it % 3 == 0) base = 16'($urandom);
      word = base ^ 16'($urandom & $urandom & $urandom);
      wait_scan();
      check_regs("rand");
      if ($urandom_range(0, 1) == 1) bus_write(ADDR_PRESSED, $urandom);
      bus_write(ADDR_IRQ_MASK, $urandom);
      chk("rand_irq_after_wr", 32'(irq), 32'(irq_m()));
    end
    bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
    bus_write(ADDR_SCAN_COUNT, 32'h0);
    bus_read(ADDR_SCAN_COUNT, d);
    chk("rand_scan_count", d, scans_m);

    // Reset in the middle of a scan.
    wait_load();
    for (int i = 0; i < 10 && !shift_clk; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_sclk", 32'(shift_clk), 32'd0);
    chk("midrst_loadn", 32'(shift_loadn), 32'd1);
    reset = 1'b0;
    model_reset();
    bus_read(ADDR_STATUS, d);     chk("midrst_status", d, 32'd0);
    bus_read(ADDR_SCAN_COUNT, d); chk("midrst_scan_count", d, 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    wait_load();
    chk("midrst_next_load", 32'(rel_cnt), 32'(SI));
    repeat (UPD_OFS) @(posedge clk);
    #1;
    model_scan(word);
    check_regs("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_buttons_scanner.md
# display_buttons_scanner

Controller that sequences the display board's parallel-in/serial-out button shift register through SHIFT_LOAD, SHIFT_CLKIN and SHIFT_OUT. It periodically loads the register, clocks the bits out and debounces them. It exposes button state, sticky press flags and an interrupt to the CPU through an Avalon-MM slave in the SoC. It replaces ad-hoc software bit-banging and owns the shift-register timing exclusively.

## Interface
- CLK_DIV, 25: clk cycles per half-period of shift_clk, and the length of the load pulse. Minimum 2.
- NBITS, 16: number of button bits in the shift chain, 1..32.
- SCAN_INTERVAL, 50000: clk cycles from one scan start to the next. Must be ≥ (2·NBITS+2)·CLK_DIV.
- DEBOUNCE_SCANS, 4: number of consecutive identical scans required to change the debounced state. Range 2..8.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- shift_in  in  1  serial data from the register (SHIFT_OUT); buttons are active-low
- shift_loadn  out  1  parallel load, active-low (SHIFT_LOAD); registered
- shift_clk  out  1  shift clock (SHIFT_CLKIN); registered
- avs_address  in  2  word address
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, valid 1 cycle after avs_read
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- irq  out  1  level interrupt = |(PRESSED & IRQ_MASK); registered

## Operation
- Registers (unused bits read 0):
  - 0 STATUS (RO): debounced state, 1 = pressed.
  - 1 PRESSED (R/W1C): sticky flag, set on a 0→1 transition of the debounced bit.
  - 2 IRQ_MASK (RW): low NBITS bits.
  - 3 SCAN_COUNT (RO): 32-bit count of completed scans, wraps at 2^32.
- Writes to addresses 0 and 3 are ignored.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, UPDATE.
  - IDLE: the interval counter runs. When it reaches SCAN_INTERVAL−1 → LOAD and the counter restarts.
  - LOAD: shift_loadn=0 for CLK_DIV cycles → SHIFT_LO.
  - SHIFT_LO: shift_clk=0 for CLK_DIV cycles. shift_in is sampled on the last cycle into bit position NBITS−1−k, MSB first, where k is the bit index → SHIFT_HI.
  - SHIFT_HI: shift_clk=1 for CLK_DIV cycles. k increments. If k=NBITS → UPDATE, else → SHIFT_LO.
  - UPDATE: one cycle. The raw word is inverted (pressed=1) and fed to the debouncer. SCAN_COUNT increments → IDLE.
- Debounce: each bit keeps a history of the last DEBOUNCE_SCANS raw samples. The debounced bit takes a value only when the whole history equals that value; otherwise it holds its previous value.
- Simultaneous events: if a W1C to PRESSED and a new rising edge on the same bit land in the same cycle, the set wins. A read in that cycle returns the pre-update value.

## Timing
- Reset values:
  - shift_loadn=1, shift_clk=0, avs_readdata=0, irq=0.
  - All registers, histories and counters are 0; FSM is IDLE.
  - The first scan starts SCAN_INTERVAL cycles after reset deasserts.
- Reset asserted mid-scan aborts the scan. Outputs take reset values on the next edge and the partial word is discarded.
- One scan from LOAD entry to UPDATE lasts (2·NBITS+1)·CLK_DIV+1 cycles, which is 826 cycles at the defaults.
- Latency from a stable press to STATUS: DEBOUNCE_SCANS scans. STATUS, PRESSED and irq update in the cycle after UPDATE.
- Read latency is fixed at 1 cycle; there is no waitrequest. A write takes effect on the next edge.
- Interval counting runs start-to-start and is independent of bus activity. A scan is never delayed.

## Structure
- Shared package display_buttons_pkg holds:
  - the state enum;
  - register address constants (ADDR_STATUS=0, ADDR_PRESSED=1, ADDR_IRQ_MASK=2, ADDR_SCAN_COUNT=3).
- Sub-module button_debounce (parameters NBITS, DEBOUNCE_SCANS):
  - inputs: sample valid strobe, raw vector;
  - outputs: debounced vector, rise-pulse vector.
- The top level contains the FSM, the counters and the register file.

## Test plan
- Timing check (CLK_DIV=2, NBITS=16, SCAN_INTERVAL=100): after reset, the first shift_loadn falls at cycle 100 and stays low for 2 cycles. Then 16 shift_clk pulses of 2 high/2 low follow, and SCAN_COUNT=1 after the first UPDATE.
- Stable press: model drives raw 0xFFFE for 4 scans → STATUS=0x0001 after the 4th scan, PRESSED=0x0001. irq=0 while IRQ_MASK=0; irq=1 after writing IRQ_MASK=0x0001.
- Bounce: raw bit 3 alternates across scans 0,1,0,1,0 → STATUS bit 3 stays 0 and PRESSED stays 0.
- W1C: with PRESSED=0x0011, write 0x0001 → PRESSED reads 0x0010, and irq follows the mask.
- Set/clear collision: W1C to bit 0 issued in the same cycle as bit 0's debounced rise → PRESSED bit 0 reads 1.
- Reset mid-scan: assert reset during SHIFT_HI → next cycle shift_clk=0, shift_loadn=1, STATUS=0 and SCAN_COUNT=0. The next scan starts SCAN_INTERVAL cycles after reset deasserts.
